// File: rtl/mem_ctrl.sv
// Memory access controller: holds MAR/MDR and sequences single-cycle RAM read/write strobes.
// Optional sticky request-error flag `req_err` is built when MEM_REQ_ERR_EN is defined.
module mem_ctrl #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [DW-1:0] BusMuxOut,
  input  logic          MARin,
  input  logic          MDRin,
  input  logic          rd_req,
  input  logic          wr_req,
  output logic [DW-1:0] MDR_q,
  output logic          busy,
  output logic          done,
`ifdef MEM_REQ_ERR_EN
  output logic          req_err,
`endif
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_read,
  output logic          ram_write,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ram_read_q, ram_read_d;
  logic          ram_write_q, ram_write_d;

  // Upper bus bits never reach the MAR; addresses simply wrap.
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, BusMuxOut[DW-1:AW]};

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      IDLE: begin
        if (MARin) mar_d = BusMuxOut[AW-1:0];
        if (MDRin) mdr_d = BusMuxOut;
        if (wr_req)      state_d = WR_ISSUE;
        else if (rd_req) state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        mdr_d   = ram_rdata;
        state_d = DONE;
      end
      WR_ISSUE: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered yet line up with it.
    busy_d      = (state_d == RD_ISSUE) || (state_d == RD_CAPT) || (state_d == WR_ISSUE);
    done_d      = (state_d == DONE);
    ram_read_d  = (state_d == RD_ISSUE);
    ram_write_d = (state_d == WR_ISSUE);
  end

`ifdef MEM_REQ_ERR_EN
  logic req_err_q, req_err_d;

  always_comb begin
    req_err_d = req_err_q
              | ((state_q != IDLE) && (rd_req || wr_req))
              | ((state_q == IDLE) && rd_req && wr_req);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) req_err_q <= 1'b0;
    else          req_err_q <= req_err_d;
  end

  assign req_err = req_err_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
    end
  end

  assign MDR_q     = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = mar_q;
  assign ram_wdata = mdr_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a behavioural 512x32 registered-read RAM.
module tb_mem_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, rd_req, wr_req;
  logic [31:0] MDR_q;
  logic        busy, done;
`ifdef MEM_REQ_ERR_EN
  logic        req_err;
`endif
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_read, ram_write;
  logic [31:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_read;
    logic [8:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t sb[$];

  logic [31:0] mem [512];

  mem_ctrl #(.AW(9), .DW(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .MDR_q     (MDR_q),
    .busy      (busy),
    .done      (done),
`ifdef MEM_REQ_ERR_EN
    .req_err   (req_err),
`endif
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_rdata (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: write has priority, read data appears after the edge that samples ram_read.
  always @(posedge clock) begin
    if (ram_write)     mem[ram_addr] <= ram_wdata;
    else if (ram_read) ram_rdata     <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadReg(input bit mar, input bit mdr, input logic [31:0] value);
    BusMuxOut = value;
    MARin     = mar;
    MDRin     = mdr;
    tick();
    MARin     = 1'b0;
    MDRin     = 1'b0;
  endtask

  // Drives one request, pushes its expectation and follows it to the done pulse.
  task automatic applyStimulus(input bit rd, input bit wr, input bit load_mar,
                               input logic [31:0] bus, input logic [8:0] addr,
                               input logic [31:0] exp_data, input bit poke);
    txn_t t;
    int   cycles;
    t.is_read = rd && !wr;
    t.addr    = addr;
    t.data    = exp_data;
    sb.push_back(t);

    rd_req    = rd;
    wr_req    = wr;
    MARin     = load_mar;
    BusMuxOut = bus;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    MARin  = 1'b0;

    checkOutput("strobe_rd", {31'd0, ram_read}, {31'd0, t.is_read});
    checkOutput("strobe_wr", {31'd0, ram_write}, {31'd0, !t.is_read});
    checkOutput("busy_issue", {31'd0, busy}, 32'd1);
    checkOutput("addr_issue", {23'd0, ram_addr}, {23'd0, addr});
    if (!t.is_read) checkOutput("wdata_issue", ram_wdata, exp_data);

    cycles = 0;
    while (!done && cycles < 8) begin
      tick();
      cycles++;
      if (poke && cycles == 1) begin
        BusMuxOut = 32'h77;
        MDRin     = 1'b1;
      end else begin
        MDRin = 1'b0;
      end
      if (!done) checkOutput("strobe_once", {30'd0, ram_read, ram_write}, 32'd0);
    end
    MDRin = 1'b0;

    if (!done) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", cycles, t.is_read ? 32'd2 : 32'd1);
      checkOutput("busy_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("sb_empty", 32'd0, 32'd1);
      end else begin
        t = sb.pop_front();
        if (t.is_read) checkOutput("rd_data", MDR_q, t.data);
        else           checkOutput("mem_wr", mem[t.addr], t.data);
      end
    end
    tick();
    checkOutput("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    BusMuxOut = '0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = i * 7 + 1;
    mem[95] = 32'h4;

    repeat (2) tick();
    checkOutput("rst_mdr", MDR_q, 32'd0);
    checkOutput("rst_strobes", {28'd0, busy, done, ram_read, ram_write}, 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("rel_mdr", MDR_q, 32'd0);
    checkOutput("rel_addr", {23'd0, ram_addr}, 32'd0);
    checkOutput("rel_busy_done", {30'd0, busy, done}, 32'd0);
`ifdef MEM_REQ_ERR_EN
    checkOutput("rel_req_err", {31'd0, req_err}, 32'd0);
`endif

    loadReg(1'b1, 1'b0, 32'd130);
    checkOutput("mar_load", {23'd0, ram_addr}, 32'd130);
    loadReg(1'b0, 1'b1, 32'h0000ABBA);
    checkOutput("mdr_load", MDR_q, 32'h0000ABBA);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 9'd130, 32'h0000ABBA, 1'b0);

    loadReg(1'b0, 1'b1, 32'd0);
    checkOutput("mdr_clear", MDR_q, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 9'd130, 32'h0000ABBA, 1'b0);

    loadReg(1'b1, 1'b0, 32'd95);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 9'd95, 32'h4, 1'b1);
    checkOutput("mdr_locked", MDR_q, 32'h4);

    loadReg(1'b1, 1'b0, 32'h25F);
    checkOutput("mar_wrap", {23'd0, ram_addr}, 32'h05F);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 9'd95, 32'h4, 1'b0);

    loadReg(1'b1, 1'b0, 32'd42);
    loadReg(1'b0, 1'b1, 32'h1234);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 9'd42, 32'h1234, 1'b0);
`ifdef MEM_REQ_ERR_EN
    checkOutput("req_err_both", {31'd0, req_err}, 32'd1);
`endif

    // MAR load in the same cycle as the request must feed the transaction.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd130, 9'd130, 32'h0000ABBA, 1'b0);

    loadReg(1'b1, 1'b0, 32'd95);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checkOutput("midrd_strobe", {31'd0, ram_read}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrd_outs", {28'd0, busy, done, ram_read, ram_write}, 32'd0);
    checkOutput("midrd_mdr", MDR_q, 32'd0);
    checkOutput("midrd_addr", {23'd0, ram_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midrd_no_done", {31'd0, done}, 32'd0);
    end
    reset_n = 1'b1;
    tick();
`ifdef MEM_REQ_ERR_EN
    checkOutput("req_err_cleared", {31'd0, req_err}, 32'd0);
`endif
    loadReg(1'b1, 1'b0, 32'd95);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 9'd95, 32'h4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the CPU datapath bus and the 512x32 synchronous RAM. It holds the memory address register (MAR) and the memory data register (MDR) and turns single-cycle control-unit requests into correctly timed RAM read/write strobes. It absorbs the RAM's one-cycle registered read latency and returns a `done` pulse, so the control unit sequences loads and stores without counting cycles.

## Interface
Parameters:
- `AW`, 9: RAM address width; MAR width.
- `DW`, 32: data width; bus, MDR and RAM data width.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `BusMuxOut`  in  DW  datapath bus.
- `MARin`  in  1  load MAR from `BusMuxOut[AW-1:0]`.
- `MDRin`  in  1  load MDR from `BusMuxOut`.
- `rd_req`  in  1  start RAM read of MAR into MDR.
- `wr_req`  in  1  start RAM write of MDR to MAR.
- `MDR_q`  out  DW  MDR contents, to the bus mux.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.
- `req_err`  out  1  sticky request error; present only under `MEM_REQ_ERR_EN`.
- `ram_addr`  out  AW  RAM address; always equals MAR.
- `ram_wdata`  out  DW  RAM write data; always equals MDR.
- `ram_read`  out  1  RAM read strobe.
- `ram_write`  out  1  RAM write strobe.
- `ram_rdata`  in  DW  RAM registered read data.

## Operation
- FSM states are `IDLE`, `RD_ISSUE`, `RD_CAPT`, `WR_ISSUE`, `DONE`.
- `IDLE`:
  - `wr_req` goes to `WR_ISSUE`; else `rd_req` goes to `RD_ISSUE`.
  - If both are high, write wins, matching RAM priority.
  - `MARin`/`MDRin` load on the edge. If a load and a request coincide, the register loads first and the transaction uses the new value.
- `RD_ISSUE`: `ram_read`=1 for exactly one cycle; next state `RD_CAPT`.
- `RD_CAPT`: MDR <= `ram_rdata`; next state `DONE`.
- `WR_ISSUE`: `ram_write`=1 for exactly one cycle; next state `DONE`.
- `DONE`: `done`=1; next state `IDLE`.
- `busy` = 1 in `RD_ISSUE`, `RD_CAPT` and `WR_ISSUE`.
- `ram_read` and `ram_write` are never both high.
- Outside `IDLE`:
  - MAR and MDR are locked.
  - `MARin`, `MDRin`, `rd_req` and `wr_req` are ignored; no queuing.
- MAR takes bus bits [AW-1:0]; upper bits are dropped, so address 0x1FF is followed by wrap to 0 for bus value 0x200.
- Reset (async, any state):
  - state `IDLE`; MAR=0, MDR=0.
  - `busy`=`done`=`ram_read`=`ram_write`=0; `req_err`=0.
- Reset asserted mid-write: the RAM is written only if the `WR_ISSUE` edge already occurred.

## Timing
- Request sampled at edge E0 in `IDLE`.
- Read:
  - `ram_read` is high in the cycle E0–E1.
  - RAM latches q at E1.
  - MDR updates at E2.
  - `done` is high in E2–E3.
  - Back in `IDLE` at E3; next request accepted at E3.
- Write:
  - `ram_write` is high in E0–E1; RAM updated at E1.
  - `done` is high in E1–E2; `IDLE` at E2.
- Throughput: read 3 cycles, write 2 cycles.
- `MDR_q`, `ram_addr` and `ram_wdata` are registered; no combinational path from inputs.

## Configuration
- `MEM_REQ_ERR_EN` defined:
  - `req_err` port and logic are present.
  - `req_err` sets on any edge where `rd_req` or `wr_req` is high outside `IDLE`, or where both are high in `IDLE`.
  - It stays set until `reset_n` is asserted.
- `MEM_REQ_ERR_EN` undefined:
  - The port is absent.
  - Such requests are silently dropped or resolved (write wins); all other behaviour is identical.

## Test plan
- Reset, then release → `MDR_q`=0, `ram_addr`=0, `busy`=`done`=0; with the macro defined, `req_err`=0.
- Store then load:
  - MAR<=130, MDR<=0x0000ABBA, `wr_req` → `ram_write` for 1 cycle, `done` 1 cycle later.
  - MDR<=0, then `rd_req` → `MDR_q`=0x0000ABBA exactly 2 edges after the request.
- Preloaded mem[95]=0x4:
  - MAR<=95, `rd_req` → `MDR_q`=0x4.
  - Raise `MDRin` with bus 0x77 during `RD_CAPT` → `MDR_q` stays 0x4.
- MAR wrap: bus 0x25F with `MARin` → `ram_addr`=0x05F; a read returns mem[95].
- `rd_req` and `wr_req` together in `IDLE` with MAR=42, MDR=0x1234:
  - Only `ram_write` is issued.
  - mem[42]=0x1234 afterwards.
  - With the macro defined, `req_err`=1.
- Assert `reset_n`=0 during `RD_ISSUE` → outputs zero immediately; no `done` pulse; the next read after release behaves normally.
